bcd_counter_display: RTL and testbench
======================================

// Module: bcd_counter_display
// PURPOSE
//   N-digit decimal (BCD) up/down counter with a built-in clock-enable prescaler and per-digit
//   7-segment encoding. It is the parametrised successor to the fixed six-digit counter/display top.
//   It adds width, direction, parallel load and wrap signalling. It sits between the board
//   clock/reset and the seven-segment display pins.
// PARAMETERS
//   NUM_DIGITS  6  number of BCD digits (1..8); digit 0 is least significant
//   TICK_DIV    1  clk cycles per count step while en=1 (1 = count every enabled cycle, max 2^16)
//   SEG_ACT_LOW 0  1 = segment outputs inverted (common-anode display)
// PORTS
//   clk       in   1             rising-edge clock
//   reset     in   1             synchronous, active-high reset
//   en        in   1             count enable; gates the prescaler
//   up_dn     in   1             1 = count up, 0 = count down; sampled on the step cycle
//   load      in   1             synchronous parallel load
//   load_val  in   4*NUM_DIGITS  BCD value loaded when load=1
//   count     out  4*NUM_DIGITS  registered BCD count
//   seg       out  7*NUM_DIGITS  seg[7i+6:7i] = {g,f,e,d,c,b,a} for digit i, registered
//   wrap      out  1             one-cycle pulse on full-range wrap
// BEHAVIOUR
//   - Reset (sync, highest priority):
//     - count=0, prescaler=0, wrap=0.
//     - seg = code of 0 on every digit (0x3F per digit, inverted if SEG_ACT_LOW).
//   - Priority per edge: reset > load > step.
//   - Prescaler:
//     - Counts clk edges with en=1; it holds while en=0.
//     - step is asserted on the edge where prescaler==TICK_DIV-1; the prescaler then returns to 0.
//   - load:
//     - count <= load_val and the prescaler clears.
//     - Any nibble >9 loads as 0.
//     - No wrap pulse. A load asserted together with step wins; the step is discarded.
//   - Step, up:
//     - Digit 0 increments. A digit at 9 becomes 0 and carries into the next digit.
//     - All digits 9 -> all 0, with wrap=1 on the same edge.
//   - Step, down:
//     - A digit at 0 becomes 9 and borrows from the next digit.
//     - All 0 -> all 9, with wrap=1.
//   - Latency:
//     - count changes on the edge where step is taken.
//     - seg reflects the new count one clk later (registered decode).
//     - wrap is registered and aligned with count.
//   - Direction change mid-run takes effect on the next step; no glitch or extra step.
//   - en low mid-division freezes the prescaler phase; it resumes where it stopped.
//   - Decoder: 0-9 use standard codes
//     (0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F, active-high).
//     Non-BCD nibbles cannot occur.
// CONFIGURATION
//   LEAD_ZERO_BLANK_EN
//     - Defined: any digit i>0 is blanked (seg=0, or all-ones if SEG_ACT_LOW) when it and all
//       higher digits are 0. Digit 0 is always shown. Reset shows a single '0'.
//     - Undefined: all digits are always displayed, including leading zeros.
//     - count and wrap are identical in both builds.
// STRUCTURE
//   - Shared package/header bcd7seg_pkg holds:
//     - the 7-bit segment code constants for 0-9 and BLANK;
//     - the BCD digit width constant (4);
//     - the seg bit-order definition.
//   - Sub-module bcd_digit holds one decade stage. It has inputs step, up_dn, carry_in and load
//     nibble, and outputs digit and carry_out. It is instantiated NUM_DIGITS times in a generate
//     loop with a ripple carry.
//   - Top level holds the prescaler, wrap register, decode/blank logic and output register.
// TESTING
//   1. Reset: hold reset 3 cycles with en=1.
//      -> count=0, wrap=0, seg=0x3F per digit (LEAD_ZERO_BLANK_EN: digit0=0x3F, others 0x00).
//   2. Up ripple (NUM_DIGITS=6, TICK_DIV=1): load 000999, en=1, up_dn=1, one step.
//      -> count=001000, seg digit3=0x06 one cycle later.
//   3. Up wrap: load 999999, one step.
//      -> count=000000, wrap high exactly 1 cycle.
//   4. Down wrap/borrow: load 000000, up_dn=0, one step.
//      -> count=999999, wrap=1. Next step -> 999998, wrap=0.
//   5. Prescaler: TICK_DIV=4, en=1 for 12 cycles from reset.
//      -> count=3, steps on cycles 4, 8, 12.
//      Drop en for 5 cycles mid-division -> phase held, no step.
//   6. Priority: load=1 (val 123456) on a step cycle with reset=0 -> count=123456, no increment.
//      Assert reset during load -> count=0. Load nibble 0xA -> that digit loads as 0.

Source files
------------

// File: rtl/bcd7seg_pkg.sv
// Shared definitions for the BCD counter / 7-segment display slice.
// Holds the BCD digit width, the segment field width and bit order,
// the segment codes for 0-9 and BLANK, and a digit-to-segment decoder.
// Segment field per digit is {g,f,e,d,c,b,a}: bit 0 = a ... bit 6 = g.
package bcd7seg_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    // Segment bit positions inside one 7-bit digit field
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [SEG_W-1:0] seg_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Active-high codes
    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_BLANK = 7'h00;

    // Non-BCD nibbles never reach the decoder; they map to BLANK for safety.
    function automatic seg_t bcd_to_seg(input bcd_t d);
        seg_t code;
        case (d)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bcd_counter_display_if.sv
// Control/status bundle of bcd_counter_display.
//   en, up_dn, load, load_val : driven by the master (controller)
//   count, seg, wrap          : driven by the slave (counter/display)
// NUM_DIGITS must match the attached counter.
interface bcd_counter_display_if
    import bcd7seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6
);

    logic                        en;
    logic                        up_dn;
    logic                        load;
    logic [BCD_W*NUM_DIGITS-1:0] load_val;
    logic [BCD_W*NUM_DIGITS-1:0] count;
    logic [SEG_W*NUM_DIGITS-1:0] seg;
    logic                        wrap;

    modport master (
        output en, up_dn, load, load_val,
        input  count, seg, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output count, seg, wrap
    );

endinterface

// File: rtl/bcd_digit.sv
// One decade stage of the BCD up/down counter.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   step         : count step for the whole counter this cycle
//   up_dn        : 1 = increment, 0 = decrement
//   carry_in     : lower digits all roll over (digit 0: tie to 1)
//   load         : parallel load (beats step)
//   load_nibble  : value to load; anything above 9 loads as 0
//   digit        : registered digit value
//   carry_out    : this stage rolls over on a step (combinational ripple)
module bcd_digit
    import bcd7seg_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic step,
    input  logic up_dn,
    input  logic carry_in,
    input  logic load,
    input  bcd_t load_nibble,
    output bcd_t digit,
    output logic carry_out
);

    always_comb begin
        carry_out = carry_in && (up_dn ? (digit == BCD_MAX) : (digit == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit <= '0;
        end else if (load) begin
            digit <= (load_nibble > BCD_MAX) ? '0 : load_nibble;
        end else if (step && carry_in) begin
            if (up_dn) begin
                digit <= (digit == BCD_MAX) ? '0 : digit + 4'd1;
            end else begin
                digit <= (digit == '0) ? BCD_MAX : digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with clock-enable prescaler, parallel load,
// wrap pulse and registered per-digit 7-segment outputs.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (beats load, load beats step)
//   bus   : bcd_counter_display_if.slave
//           en/up_dn/load/load_val in; count/seg/wrap out
// Parameters: NUM_DIGITS (1..8), TICK_DIV (1..65536), SEG_ACT_LOW (0/1).
// Build option: define LEAD_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 always shown); count and wrap are unaffected.
module bcd_counter_display
    import bcd7seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 6,
    parameter int unsigned TICK_DIV    = 1,
    parameter int unsigned SEG_ACT_LOW = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_counter_display_if.slave  bus
);

    localparam int unsigned CNT_W      = BCD_W * NUM_DIGITS;
    localparam int unsigned SEGS_W     = SEG_W * NUM_DIGITS;
    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    logic [15:0]         presc;
    logic                step;
    logic [NUM_DIGITS:0] carry;
    logic [CNT_W-1:0]    count_q;
    logic [SEGS_W-1:0]   seg_q;
    logic [SEGS_W-1:0]   seg_next;
    logic                wrap_q;

    // Per-digit decode, optional leading-zero blanking and polarity.
    // Walks from the most significant digit down so blanking can track
    // "this and every higher digit is zero".
    function automatic logic [SEGS_W-1:0] seg_encode(input logic [CNT_W-1:0] cnt);
        logic [SEGS_W-1:0] s;
        int unsigned       idx;
        bcd_t              d;
        seg_t              code;
`ifdef LEAD_ZERO_BLANK_EN
        logic              lead;
        lead = 1'b1;
`endif
        s = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            idx  = NUM_DIGITS - 1 - i;
            d    = cnt[idx*BCD_W +: BCD_W];
            code = bcd_to_seg(d);
`ifdef LEAD_ZERO_BLANK_EN
            lead = lead && (d == '0);
            if (lead && (idx != 0)) begin
                code = SEG_BLANK;
            end
`endif
            s[idx*SEG_W +: SEG_W] = (SEG_ACT_LOW != 0) ? ~code : code;
        end
        return s;
    endfunction

    // Prescaler: advances only on enabled cycles, so dropping en holds the phase.
    always_comb begin
        step = bus.en && (presc == PRESC_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset || bus.load) begin
            presc <= '0;
        end else if (bus.en) begin
            presc <= step ? '0 : presc + 16'd1;
        end
    end

    // Ripple chain: digit i changes when every lower digit rolls over.
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk         (clk),
            .reset       (reset),
            .step        (step),
            .up_dn       (bus.up_dn),
            .carry_in    (carry[g]),
            .load        (bus.load),
            .load_nibble (bus.load_val[g*BCD_W +: BCD_W]),
            .digit       (count_q[g*BCD_W +: BCD_W]),
            .carry_out   (carry[g+1])
        );
    end

    // Full-range rollover is a carry out of the top digit on a taken step.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= step && !bus.load && carry[NUM_DIGITS];
        end
    end

    always_comb begin
        seg_next = seg_encode(count_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= seg_encode('0);
        end else begin
            seg_q <= seg_next;
        end
    end

    assign bus.count = count_q;
    assign bus.seg   = seg_q;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed self-checking bench for bcd_counter_display.
// Three instances: 6 digits / TICK_DIV=1, 6 digits / TICK_DIV=4,
// 2 digits / active-low segments. Honors LEAD_ZERO_BLANK_EN.
module tb_bcd_counter_display;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_counter_display_if #(.NUM_DIGITS(6)) bus_main ();
    bcd_counter_display_if #(.NUM_DIGITS(6)) bus_div ();
    bcd_counter_display_if #(.NUM_DIGITS(2)) bus_low ();

    bcd_counter_display #(.NUM_DIGITS(6), .TICK_DIV(1), .SEG_ACT_LOW(0)) u_main (
        .clk(clk), .reset(reset), .bus(bus_main)
    );
    bcd_counter_display #(.NUM_DIGITS(6), .TICK_DIV(4), .SEG_ACT_LOW(0)) u_div (
        .clk(clk), .reset(reset), .bus(bus_div)
    );
    bcd_counter_display #(.NUM_DIGITS(2), .TICK_DIV(1), .SEG_ACT_LOW(1)) u_low (
        .clk(clk), .reset(reset), .bus(bus_low)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [41:0] exp_seg6;
        logic [13:0] exp_seg2;
`ifdef LEAD_ZERO_BLANK_EN
        exp_seg6 = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F};
        exp_seg2 = {7'h7F, 7'h40};
`else
        exp_seg6 = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        exp_seg2 = {7'h40, 7'h40};
`endif
        reset = 1'b1;
        bus_main.en = 1'b1; bus_div.en = 1'b1; bus_low.en = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus_main.count !== 24'h000000) begin
            failures++; $display("FAIL reset_count: got %h expected %h", bus_main.count, 24'h000000);
        end
        checks++;
        if (bus_main.wrap !== 1'b0) begin
            failures++; $display("FAIL reset_wrap: got %b expected 0", bus_main.wrap);
        end
        checks++;
        if (bus_main.seg !== exp_seg6) begin
            failures++; $display("FAIL reset_seg: got %h expected %h", bus_main.seg, exp_seg6);
        end
        checks++;
        if (bus_low.seg !== exp_seg2) begin
            failures++; $display("FAIL reset_seg_actlow: got %h expected %h", bus_low.seg, exp_seg2);
        end
        reset = 1'b0;
        bus_main.en = 1'b0; bus_low.en = 1'b0;
    endtask

    task automatic test_prescaler();
        // bus_div.en is already 1; the first post-reset edge is cycle 1
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++;
            if (bus_div.count !== 24'(c / 4)) begin
                failures++; $display("FAIL presc_cycle%0d: got %h expected %h", c, bus_div.count, 24'(c / 4));
            end
        end
        repeat (2) tick();          // phase now 2 of 4
        bus_div.en = 1'b0;
        repeat (5) tick();
        checks++;
        if (bus_div.count !== 24'h000003) begin
            failures++; $display("FAIL presc_hold: got %h expected %h", bus_div.count, 24'h000003);
        end
        bus_div.en = 1'b1;
        tick();
        checks++;
        if (bus_div.count !== 24'h000003) begin
            failures++; $display("FAIL presc_resume_early: got %h expected %h", bus_div.count, 24'h000003);
        end
        tick();
        bus_div.en = 1'b0;
        checks++;
        if (bus_div.count !== 24'h000004) begin
            failures++; $display("FAIL presc_resume_step: got %h expected %h", bus_div.count, 24'h000004);
        end
    endtask

    task automatic test_up_ripple();
        logic [41:0] exp_seg;
`ifdef LEAD_ZERO_BLANK_EN
        exp_seg = {7'h00, 7'h00, 7'h06, 7'h3F, 7'h3F, 7'h3F};
`else
        exp_seg = {7'h3F, 7'h3F, 7'h06, 7'h3F, 7'h3F, 7'h3F};
`endif
        bus_main.load = 1'b1; bus_main.load_val = 24'h000999;
        tick();
        bus_main.load = 1'b0; bus_main.en = 1'b1; bus_main.up_dn = 1'b1;
        tick();
        bus_main.en = 1'b0;
        checks++;
        if (bus_main.count !== 24'h001000) begin
            failures++; $display("FAIL up_ripple_count: got %h expected %h", bus_main.count, 24'h001000);
        end
        tick();
        checks++;
        if (bus_main.seg !== exp_seg) begin
            failures++; $display("FAIL up_ripple_seg: got %h expected %h", bus_main.seg, exp_seg);
        end
    endtask

    task automatic test_up_wrap();
        bus_main.load = 1'b1; bus_main.load_val = 24'h999999;
        tick();
        bus_main.load = 1'b0;
        checks++;
        if (bus_main.wrap !== 1'b0 || bus_main.count !== 24'h999999) begin
            failures++; $display("FAIL load_no_wrap: got %h/%b expected 999999/0", bus_main.count, bus_main.wrap);
        end
        bus_main.en = 1'b1; bus_main.up_dn = 1'b1;
        tick();
        bus_main.en = 1'b0;
        checks++;
        if (bus_main.count !== 24'h000000 || bus_main.wrap !== 1'b1) begin
            failures++; $display("FAIL up_wrap: got %h/%b expected 000000/1", bus_main.count, bus_main.wrap);
        end
        tick();
        checks++;
        if (bus_main.wrap !== 1'b0) begin
            failures++; $display("FAIL up_wrap_pulse_len: got %b expected 0", bus_main.wrap);
        end
    endtask

    task automatic test_down_wrap();
        bus_main.load = 1'b1; bus_main.load_val = 24'h000000; bus_main.up_dn = 1'b0;
        tick();
        bus_main.load = 1'b0; bus_main.en = 1'b1;
        tick();
        checks++;
        if (bus_main.count !== 24'h999999 || bus_main.wrap !== 1'b1) begin
            failures++; $display("FAIL down_wrap: got %h/%b expected 999999/1", bus_main.count, bus_main.wrap);
        end
        tick();
        bus_main.en = 1'b0;
        checks++;
        if (bus_main.count !== 24'h999998 || bus_main.wrap !== 1'b0) begin
            failures++; $display("FAIL down_next: got %h/%b expected 999998/0", bus_main.count, bus_main.wrap);
        end
    endtask

    task automatic test_back_to_back();
        logic [41:0] exp_seg;
`ifdef LEAD_ZERO_BLANK_EN
        exp_seg = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h66};
`else
        exp_seg = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h66};
`endif
        bus_main.load = 1'b1; bus_main.load_val = 24'h000005;
        tick();
        bus_main.load = 1'b0; bus_main.en = 1'b1; bus_main.up_dn = 1'b1;
        tick();
        checks++;
        if (bus_main.count !== 24'h000006) begin
            failures++; $display("FAIL dir_up: got %h expected %h", bus_main.count, 24'h000006);
        end
        bus_main.up_dn = 1'b0;
        tick();
        checks++;
        if (bus_main.count !== 24'h000005) begin
            failures++; $display("FAIL dir_change: got %h expected %h", bus_main.count, 24'h000005);
        end
        tick();
        bus_main.en = 1'b0;
        checks++;
        if (bus_main.count !== 24'h000004) begin
            failures++; $display("FAIL dir_down: got %h expected %h", bus_main.count, 24'h000004);
        end
        tick();
        checks++;
        if (bus_main.seg !== exp_seg) begin
            failures++; $display("FAIL dir_seg: got %h expected %h", bus_main.seg, exp_seg);
        end
    endtask

    task automatic test_priority();
        bus_main.en = 1'b1; bus_main.up_dn = 1'b1;
        bus_main.load = 1'b1; bus_main.load_val = 24'h123456;
        tick();
        bus_main.load = 1'b0; bus_main.en = 1'b0;
        checks++;
        if (bus_main.count !== 24'h123456) begin
            failures++; $display("FAIL load_beats_step: got %h expected %h", bus_main.count, 24'h123456);
        end
        bus_main.load = 1'b1; bus_main.load_val = 24'h654321; reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus_main.count !== 24'h000000 || bus_main.wrap !== 1'b0) begin
            failures++; $display("FAIL reset_beats_load: got %h/%b expected 000000/0", bus_main.count, bus_main.wrap);
        end
        bus_main.load_val = 24'h12A456;
        tick();
        checks++;
        if (bus_main.count !== 24'h120456) begin
            failures++; $display("FAIL load_nibble_A: got %h expected %h", bus_main.count, 24'h120456);
        end
        bus_main.load_val = 24'h9F9F90;
        tick();
        bus_main.load = 1'b0;
        checks++;
        if (bus_main.count !== 24'h909090) begin
            failures++; $display("FAIL load_nibble_F: got %h expected %h", bus_main.count, 24'h909090);
        end
    endtask

    task automatic test_act_low();
        logic [13:0] exp_seg;
        bus_low.load = 1'b1; bus_low.load_val = 8'h47;
        tick();
        bus_low.load = 1'b0;
        tick();
        checks++;
        if (bus_low.seg !== {7'h19, 7'h78}) begin
            failures++; $display("FAIL actlow_47: got %h expected %h", bus_low.seg, {7'h19, 7'h78});
        end
`ifdef LEAD_ZERO_BLANK_EN
        exp_seg = {7'h7F, 7'h78};
`else
        exp_seg = {7'h40, 7'h78};
`endif
        bus_low.load = 1'b1; bus_low.load_val = 8'h07;
        tick();
        bus_low.load = 1'b0;
        tick();
        checks++;
        if (bus_low.seg !== exp_seg) begin
            failures++; $display("FAIL actlow_07: got %h expected %h", bus_low.seg, exp_seg);
        end
    endtask

    initial begin
        bus_main.en = 1'b0; bus_main.up_dn = 1'b1; bus_main.load = 1'b0; bus_main.load_val = '0;
        bus_div.en  = 1'b0; bus_div.up_dn  = 1'b1; bus_div.load  = 1'b0; bus_div.load_val  = '0;
        bus_low.en  = 1'b0; bus_low.up_dn  = 1'b1; bus_low.load  = 1'b0; bus_low.load_val  = '0;
        test_reset();
        test_prescaler();
        test_up_ripple();
        test_up_wrap();
        test_down_wrap();
        test_back_to_back();
        test_priority();
        test_act_low();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
